// File: rtl/reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter
// Shares the single write port of a register bank among NUM_REQ requesters.
// A round-robin arbiter picks one pending request in IDLE, latches its address
// and data, and in the following WRITE cycle drives a one-hot load strobe,
// the shared write data and a one-cycle ack back to the winner. A RECOVER
// cycle follows so the winner has one edge to drop its request.
//
// Optional feature macro: REG_ARB_REQ0_PRIORITY_EN
//   defined   : requester 0 has absolute priority and does not move the
//               round-robin pointer; requesters 1..N-1 share round-robin.
//   undefined : pure round-robin over all requesters.
//
// Ports:
//   sysclk        in   clock
//   sysreset      in   asynchronous, active-high reset
//   i_req         in   [NUM_REQ]         level request, held until acked
//   i_req_addr    in   [NUM_REQ*ADDR_W]  requester i at [i*ADDR_W +: ADDR_W]
//   i_req_data    in   [NUM_REQ*16]      requester i at [i*16 +: 16]
//   o_ack         out  [NUM_REQ]         one-hot, one-cycle ack to the winner
//   o_load_out    out  [NUM_REGS]        one-hot load strobes to the bank
//   o_data_out    out  [16]              shared write data, zero-extended
//   o_busy        out  1                 high while not in IDLE
//   o_err         out  1                 pulse when acked address >= NUM_REGS
//   o_last_grant  out  [clog2(NUM_REQ)]  index of the most recent winner
// ----------------------------------------------------------------------------
// state     | meaning
// S_IDLE    | waiting for a request; arbitrate and latch winner on any req
// S_WRITE   | one cycle: ack winner, strobe load (or flag err)
// S_RECOVER | one cycle: all strobes low, winner drops req
// ----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    sysclk,
    input  logic                    sysreset,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*16-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]      o_ack,
    output logic [NUM_REGS-1:0]     o_load_out,
    output logic [15:0]             o_data_out,
    output logic                    o_busy,
    output logic                    o_err,
    output logic [PTR_W-1:0]        o_last_grant
);

    localparam logic [15:0] DATA_MASK = 16'((33'd1 << DATA_W) - 33'd1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_rr;
    logic [PTR_W-1:0]    r_winner;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_data;

    logic                w_found;
    logic [PTR_W-1:0]    w_winner;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [15:0]         w_sel_data;
    logic [PTR_W-1:0]    w_rr_nxt;
    logic                w_in_range;
    int                  w_best_dist;
    int                  w_dist;

    // Round-robin: the requesting index closest to r_rr (walking upward,
    // wrapping modulo NUM_REQ) wins.
    always_comb begin
        w_found     = 1'b0;
        w_winner    = '0;
        w_best_dist = NUM_REQ;
        w_dist      = 0;
`ifdef REG_ARB_REQ0_PRIORITY_EN
        if (i_req[0]) begin
            w_found     = 1'b1;
            w_winner    = '0;
            w_best_dist = -1;
        end
`endif
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j - int'(r_rr) + NUM_REQ) % NUM_REQ;
            if (i_req[j] && (w_dist < w_best_dist)) begin
                w_found     = 1'b1;
                w_winner    = PTR_W'(j);
                w_best_dist = w_dist;
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_winner == PTR_W'(j)) begin
                w_sel_addr = i_req_addr[j*ADDR_W +: ADDR_W];
                w_sel_data = i_req_data[j*16 +: 16];
            end
        end
    end

    always_comb begin
        w_rr_nxt = (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
`ifdef REG_ARB_REQ0_PRIORITY_EN
        // A requester-0 grant leaves the round-robin order of the others alone.
        if (r_winner == '0) begin
            w_rr_nxt = r_rr;
        end
`endif
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_state_nxt = S_WRITE;
            S_WRITE:   w_state_nxt = S_RECOVER;
            S_RECOVER: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_rr     <= '0;
            r_winner <= '0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_found) begin
                r_winner <= w_winner;
                r_addr   <= w_sel_addr;
                r_data   <= w_sel_data & DATA_MASK;
            end
            if (r_state == S_WRITE) begin
                r_rr <= w_rr_nxt;
            end
        end
    end

    // Strobes decode straight from state so an async reset removes them at once.
    assign w_in_range   = (32'(r_addr) < 32'(NUM_REGS));
    assign o_ack        = (r_state == S_WRITE) ? (NUM_REQ'(1) << r_winner) : '0;
    assign o_load_out   = ((r_state == S_WRITE) && w_in_range) ?
                          (NUM_REGS'(1) << r_addr) : '0;
    assign o_err        = (r_state == S_WRITE) && !w_in_range;
    assign o_data_out   = r_data;
    assign o_busy       = (r_state != S_IDLE);
    assign o_last_grant = r_winner;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    logic        sysclk = 1'b0;
    logic        sysreset;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    logic [3:0]  a_req;
    logic [11:0] a_req_addr;
    logic [63:0] a_req_data;
    logic [3:0]  a_ack;
    logic [7:0]  a_load;
    logic [15:0] a_data;
    logic        a_busy, a_err;
    logic [1:0]  a_lg;

    logic [3:0]  b_req;
    logic [11:0] b_req_addr;
    logic [63:0] b_req_data;
    logic [3:0]  b_ack;
    logic [5:0]  b_load;
    logic [15:0] b_data;
    logic        b_busy, b_err;
    logic [1:0]  b_lg;

    typedef struct packed {
        logic [3:0]  ack;
        logic [7:0]  load;
        logic [15:0] data;
        logic        err;
        logic [1:0]  lg;
    } exp_t;

    exp_t sb_q[$];
    int   last_lat;
    int   ack_stamp;
    int   prev_stamp;
    logic ok;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .ADDR_W(3), .DATA_W(16)) dut_a (
        .sysclk(sysclk), .sysreset(sysreset),
        .i_req(a_req), .i_req_addr(a_req_addr), .i_req_data(a_req_data),
        .o_ack(a_ack), .o_load_out(a_load), .o_data_out(a_data),
        .o_busy(a_busy), .o_err(a_err), .o_last_grant(a_lg)
    );

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3), .DATA_W(8)) dut_b (
        .sysclk(sysclk), .sysreset(sysreset),
        .i_req(b_req), .i_req_addr(b_req_addr), .i_req_data(b_req_data),
        .o_ack(b_ack), .o_load_out(b_load), .o_data_out(b_data),
        .o_busy(b_busy), .o_err(b_err), .o_last_grant(b_lg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input int r, input logic [2:0] addr, input logic [15:0] data);
        a_req_addr[r*3 +: 3]  = addr;
        a_req_data[r*16 +: 16] = data;
        a_req[r] = 1'b1;
    endtask

    task automatic set_b(input int r, input logic [2:0] addr, input logic [15:0] data);
        b_req_addr[r*3 +: 3]  = addr;
        b_req_data[r*16 +: 16] = data;
        b_req[r] = 1'b1;
    endtask

    task automatic push_exp(input int r, input int addr, input logic [15:0] data);
        exp_t e;
        e.ack  = 4'(1 << r);
        e.load = 8'(1 << addr);
        e.data = data;
        e.err  = 1'b0;
        e.lg   = 2'(r);
        sb_q.push_back(e);
    endtask

    // Waits on falling edges for an ack on dut_a, pops the scoreboard and compares.
    task automatic sb_check(input string tag, input int budget, input bit drop);
        exp_t e;
        int   lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        while (lat < budget && !seen) begin
            @(negedge sysclk);
            lat++;
            if (a_ack != 4'd0) seen = 1'b1;
        end
        last_lat = lat;
        if (!seen) begin
            n_checks++;
            n_err++;
            $error("FAIL %s_timeout: observed=no ack expected=ack within %0d cycles", tag, budget);
        end else if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s_sb_empty: observed=ack %0h expected=no ack", tag, a_ack);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ack"},  32'(a_ack),  32'(e.ack));
            chk({tag, "_load"}, 32'(a_load), 32'(e.load));
            chk({tag, "_data"}, 32'(a_data), 32'(e.data));
            chk({tag, "_err"},  32'(a_err),  32'(e.err));
            chk({tag, "_lg"},   32'(a_lg),   32'(e.lg));
            chk({tag, "_busy"}, 32'(a_busy), 32'd1);
            prev_stamp = ack_stamp;
            ack_stamp  = cyc;
            if (drop) a_req = a_req & ~a_ack;
        end
    endtask

    task automatic wait_b(input string tag, input int budget);
        int lat;
        lat = 0;
        ok  = 1'b0;
        while (lat < budget && !ok) begin
            @(negedge sysclk);
            lat++;
            if (b_ack != 4'd0) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $error("FAIL %s_timeout: observed=no ack expected=ack within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=time limit expected=$finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sysreset = 1'b1;
        a_req = '0; a_req_addr = '0; a_req_data = '0;
        b_req = '0; b_req_addr = '0; b_req_data = '0;
        ack_stamp = 0; prev_stamp = 0;
        repeat (2) @(negedge sysclk);
        sysreset = 1'b0;
        @(negedge sysclk);
        chk("rst_ack",  32'(a_ack),  32'd0);
        chk("rst_load", 32'(a_load), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_err",  32'(a_err),  32'd0);
        chk("rst_lg",   32'(a_lg),   32'd0);

        // Single request from requester 1.
        set_a(1, 3'd5, 16'hBEEF);
        push_exp(1, 5, 16'hBEEF);
        sb_check("t1", 4, 1'b1);
        chk("t1_latency", 32'(last_lat), 32'd1);
        @(negedge sysclk);
        chk("t1_recover_busy", 32'(a_busy), 32'd1);
        chk("t1_recover_ack",  32'(a_ack),  32'd0);
        chk("t1_recover_load", 32'(a_load), 32'd0);
        chk("t1_data_hold",    32'(a_data), 32'hBEEF);
        @(negedge sysclk);
        chk("t1_idle_busy",    32'(a_busy), 32'd0);

        // rr pointer now 2: requesters 0 and 3 pending, 3 wins; reset mid-WRITE.
        set_a(0, 3'd1, 16'h1111);
        set_a(3, 3'd4, 16'h3333);
        push_exp(3, 4, 16'h3333);
        sb_check("t5_pre", 4, 1'b0);
        #1 sysreset = 1'b1;
        #1;
        chk("t5_async_ack",  32'(a_ack),  32'd0);
        chk("t5_async_load", 32'(a_load), 32'd0);
        chk("t5_async_busy", 32'(a_busy), 32'd0);
        @(negedge sysclk);
        sysreset = 1'b0;
        push_exp(0, 1, 16'h1111);
        sb_check("t5_post0", 4, 1'b1);
        chk("t5_post0_latency", 32'(last_lat), 32'd1);
        push_exp(3, 4, 16'h3333);
        sb_check("t5_post3", 6, 1'b1);
        chk("t5_post3_latency", 32'(last_lat), 32'd3);
        a_req = '0;
        repeat (3) @(negedge sysclk);

        // All four requesters held from reset.
        sysreset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_a(i, 3'(i), 16'hA000 + 16'(i));
            push_exp(i, i, 16'hA000 + 16'(i));
        end
        @(negedge sysclk);
        sysreset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb_check("t2", 8, 1'b1);
            if (i == 0) chk("t2_first_latency", 32'(last_lat), 32'd1);
            else        chk("t2_spacing", 32'(ack_stamp - prev_stamp), 32'd3);
        end
        a_req = '0;
        repeat (3) @(negedge sysclk);

        // Requesters 0 and 2 held continuously.
        set_a(0, 3'd6, 16'hC0C0);
        set_a(2, 3'd7, 16'hC2C2);
`ifdef REG_ARB_REQ0_PRIORITY_EN
        for (int i = 0; i < 3; i++) begin
            push_exp(0, 6, 16'hC0C0);
            sb_check("t6_prio0", 4, 1'b0);
        end
        a_req[0] = 1'b0;
        push_exp(2, 7, 16'hC2C2);
        sb_check("t6_prio2", 4, 1'b1);
        chk("t6_prio2_latency", 32'(last_lat), 32'd3);
`else
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_exp(0, 6, 16'hC0C0);
            else            push_exp(2, 7, 16'hC2C2);
            sb_check("t6_rr", 4, 1'b0);
            if (i > 0) chk("t6_rr_latency", 32'(last_lat), 32'd3);
        end
`endif
        a_req = '0;
        repeat (3) begin
            @(negedge sysclk);
            chk("idle_quiet_ack", 32'(a_ack), 32'd0);
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // Second instance: NUM_REGS=6, DATA_W=8.
        set_b(0, 3'd7, 16'h5555);
        wait_b("t3_addr7", 4);
        chk("t3_ack",  32'(b_ack),  32'h1);
        chk("t3_err",  32'(b_err),  32'd1);
        chk("t3_load", 32'(b_load), 32'd0);
        b_req = '0;
        repeat (2) @(negedge sysclk);
        chk("t3_err_pulse", 32'(b_err), 32'd0);

        set_b(1, 3'd2, 16'h12A5);
        wait_b("t4", 4);
        chk("t4_ack",  32'(b_ack),  32'h2);
        chk("t4_load", 32'(b_load), 32'b000100);
        chk("t4_data", 32'(b_data), 32'h00A5);
        chk("t4_err",  32'(b_err),  32'd0);
        b_req = '0;
        repeat (2) @(negedge sysclk);

        set_b(2, 3'd6, 16'h7777);
        wait_b("t3_addr6", 4);
        chk("t3b_err",  32'(b_err),  32'd1);
        chk("t3b_load", 32'(b_load), 32'd0);
        chk("t3b_lg",   32'(b_lg),   32'd2);
        b_req = '0;
        repeat (2) @(negedge sysclk);

        set_b(3, 3'd5, 16'hFF5A);
        wait_b("t4_addr5", 4);
        chk("t4b_load", 32'(b_load), 32'b100000);
        chk("t4b_data", 32'(b_data), 32'h005A);
        chk("t4b_err",  32'(b_err),  32'd0);
        b_req = '0;
        repeat (3) @(negedge sysclk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
